// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its helpers.
package dmem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned LANE_W = 2;
  localparam logic [WORD_W-1:0] DMEM_BASE = 32'h1000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/byte_lane_merge.sv
// Replaces one little-endian byte lane of a word with a new byte.
module byte_lane_merge
  import dmem_pkg::*;
(
  input  logic [WORD_W-1:0] old_word,
  input  logic [7:0]        byte_in,
  input  logic [LANE_W-1:0] lane,
  output logic [WORD_W-1:0] merged_c
);

  always_comb begin
    merged_c = old_word;
    case (lane)
      2'd0:    merged_c[7:0]   = byte_in;
      2'd1:    merged_c[15:8]  = byte_in;
      2'd2:    merged_c[23:16] = byte_in;
      default: merged_c[31:24] = byte_in;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory slave: one request at a time, programmable wait states, registered response.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned       DEPTH       = 64,
  parameter logic [WORD_W-1:0] BASE_ADDR   = DMEM_BASE,
  parameter int unsigned       WAIT_STATES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic              req_word_we,
  input  logic              req_byte_we,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  dmem_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              word_we_q, word_we_d;
  logic              byte_we_q, byte_we_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [WORD_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  logic [WORD_W-1:0] mem_q [DEPTH];

  logic [WORD_W-3:0] word_off;
  logic [IDX_W-1:0]  idx;
  logic              err;
  logic [WORD_W-1:0] old_word, merged_word, new_word;
  logic              wr_en_c;

  // Address decode and legality check of the latched request.
  always_comb begin
    word_off = addr_q[WORD_W-1:2] - BASE_ADDR[WORD_W-1:2];
    idx      = word_off[IDX_W-1:0];
    err      = (addr_q < BASE_ADDR)
             || (32'(word_off) >= 32'(DEPTH))
             || (word_we_q && byte_we_q)
             || (!byte_we_q && (addr_q[1:0] != 2'd0));
    old_word = mem_q[idx];
    if (word_we_q)      new_word = wdata_q;
    else if (byte_we_q) new_word = merged_word;
    else                new_word = old_word;
  end

  byte_lane_merge u_merge (
    .old_word (old_word),
    .byte_in  (wdata_q[7:0]),
    .lane     (addr_q[1:0]),
    .merged_c (merged_word)
  );

  // Next-state and output logic; the first RESP cycle evaluates and commits.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    word_we_d    = word_we_q;
    byte_we_d    = byte_we_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    wr_en_c      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          word_we_d = req_word_we;
          byte_we_d = req_byte_we;
          cnt_d     = CNT_INIT;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
          end else begin
            state_d = RESP;
            pend_d  = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          pend_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (pend_q) begin
          pend_d       = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = err;
          resp_rdata_d = err ? '0 : new_word;
          wr_en_c      = !err && (word_we_q || byte_we_q);
        end else if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        pend_d  = 1'b0;
      end
    endcase

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      word_we_q    <= 1'b0;
      byte_we_q    <= 1'b0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      word_we_q    <= word_we_d;
      byte_we_q    <= byte_we_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      if (wr_en_c) begin
        mem_q[idx] <= new_word;
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: instance 0 uses two wait states, instance 1 uses none.
module tb_data_mem_responder;

  logic        clock;
  logic        reset;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_word_we;
  logic        req_byte_we;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  int checks = 0;
  int errors = 0;

  data_mem_responder #(.DEPTH(64), .BASE_ADDR(32'h1000_0000), .WAIT_STATES(2)) u_dut_ws2 (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid[0]),
    .req_ready   (req_ready[0]),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_word_we (req_word_we),
    .req_byte_we (req_byte_we),
    .resp_valid  (resp_valid[0]),
    .resp_ready  (resp_ready[0]),
    .resp_rdata  (resp_rdata[0]),
    .resp_err    (resp_err[0])
  );

  data_mem_responder #(.DEPTH(64), .BASE_ADDR(32'h1000_0000), .WAIT_STATES(0)) u_dut_ws0 (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid[1]),
    .req_ready   (req_ready[1]),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_word_we (req_word_we),
    .req_byte_we (req_byte_we),
    .resp_valid  (resp_valid[1]),
    .resp_ready  (resp_ready[1]),
    .resp_rdata  (resp_rdata[1]),
    .resp_err    (resp_err[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a request for one accepting edge, then scramble the request bus.
  task automatic start_req(input int d, input logic [31:0] a, input logic [31:0] w,
                           input logic wwe, input logic bwe, input string tag);
    chk({tag, " req_ready before accept"}, 32'(req_ready[d]), 32'd1);
    req_addr       = a;
    req_wdata      = w;
    req_word_we    = wwe;
    req_byte_we    = bwe;
    req_valid[d]   = 1'b1;
    tick();
    req_valid[d]   = 1'b0;
    req_addr       = 32'hFFFF_FFFF;
    req_wdata      = ~w;
    req_word_we    = 1'b1;
    req_byte_we    = 1'b1;
  endtask

  task automatic wait_resp(input int d, input int exp_lat, input string tag);
    int k;
    k = 0;
    while (!resp_valid[d] && k < 20) begin
      tick();
      k++;
    end
    chk({tag, " latency"}, 32'(k), 32'(exp_lat));
    chk({tag, " req_ready low in RESP"}, 32'(req_ready[d]), 32'd0);
  endtask

  task automatic finish_resp(input int d, input string tag);
    resp_ready[d] = 1'b1;
    tick();
    resp_ready[d] = 1'b0;
    chk({tag, " req_ready after handshake"}, 32'(req_ready[d]), 32'd1);
    chk({tag, " resp_valid after handshake"}, 32'(resp_valid[d]), 32'd0);
  endtask

  task automatic txn(input int d, input logic [31:0] a, input logic [31:0] w,
                     input logic wwe, input logic bwe,
                     input logic [31:0] exp_rdata, input logic exp_err, input string tag);
    start_req(d, a, w, wwe, bwe, tag);
    wait_resp(d, (d == 0) ? 3 : 1, tag);
    chk({tag, " rdata"}, resp_rdata[d], exp_rdata);
    chk({tag, " err"}, 32'(resp_err[d]), 32'(exp_err));
    finish_resp(d, tag);
  endtask

  initial begin
    reset       = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    req_word_we = 1'b0;
    req_byte_we = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i]  = 1'b0;
      resp_ready[i] = 1'b0;
    end

    // Reset cycle, then release
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("reset req_ready", 32'(req_ready[i]), 32'd0);
      chk("reset resp_valid", 32'(resp_valid[i]), 32'd0);
      chk("reset resp_rdata", resp_rdata[i], 32'd0);
      chk("reset resp_err", 32'(resp_err[i]), 32'd0);
    end
    reset = 1'b1;
    tick();
    chk("post-reset req_ready ws2", 32'(req_ready[0]), 32'd1);
    chk("post-reset req_ready ws0", 32'(req_ready[1]), 32'd1);

    // Two-wait-state instance: stores, merges, loads, illegal requests
    txn(0, 32'h1000_0004, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, "word store");
    txn(0, 32'h1000_0006, 32'h0000_005A, 1'b0, 1'b1, 32'hDE5A_BEEF, 1'b0, "byte store lane2");
    txn(0, 32'h1000_0004, 32'h0,         1'b0, 1'b0, 32'hDE5A_BEEF, 1'b0, "load after merge");
    txn(0, 32'h1000_0002, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, "misaligned load");
    txn(0, 32'h1000_0100, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0,         1'b1, "out of range store");
    txn(0, 32'h1000_00FC, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, "last word untouched");
    txn(0, 32'h0FFF_FFFC, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, "below base load");
    txn(0, 32'h1000_0004, 32'h0,         1'b1, 1'b1, 32'h0,         1'b1, "both enables");
    txn(0, 32'h1000_0007, 32'hFFFF_FF11, 1'b0, 1'b1, 32'h115A_BEEF, 1'b0, "byte store lane3");
    txn(0, 32'h1000_0004, 32'h0000_0022, 1'b0, 1'b1, 32'h115A_BE22, 1'b0, "byte store lane0");

    // Response held off for five cycles while a new request is waved at it
    start_req(0, 32'h1000_0004, 32'h0, 1'b0, 1'b0, "hold");
    wait_resp(0, 3, "hold");
    req_valid[0] = 1'b1;
    req_addr     = 32'h1000_0008;
    req_wdata    = 32'h1234_5678;
    req_word_we  = 1'b1;
    req_byte_we  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("hold resp_valid", 32'(resp_valid[0]), 32'd1);
      chk("hold rdata", resp_rdata[0], 32'h115A_BE22);
      chk("hold req_ready", 32'(req_ready[0]), 32'd0);
      tick();
    end
    req_valid[0] = 1'b0;
    finish_resp(0, "hold release");
    txn(0, 32'h1000_0008, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, "ignored request had no effect");

    // Reset while a store sits in WAIT
    start_req(0, 32'h1000_0010, 32'h1234_5678, 1'b1, 1'b0, "reset in wait");
    tick();
    reset = 1'b0;
    tick();
    chk("reset in wait resp_valid", 32'(resp_valid[0]), 32'd0);
    chk("reset in wait req_ready", 32'(req_ready[0]), 32'd0);
    reset = 1'b1;
    tick();
    chk("reset in wait req_ready after", 32'(req_ready[0]), 32'd1);
    for (int i = 0; i < 3; i++) tick();
    chk("reset in wait no late response", 32'(resp_valid[0]), 32'd0);
    txn(0, 32'h1000_0010, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, "abandoned store not written");
    txn(0, 32'h1000_0004, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, "reset cleared memory");

    // Zero-wait-state instance: store then back-to-back loads
    txn(1, 32'h1000_0008, 32'hA5A5_0F0F, 1'b1, 1'b0, 32'hA5A5_0F0F, 1'b0, "ws0 store");
    txn(1, 32'h1000_000B, 32'h0000_0077, 1'b0, 1'b1, 32'h77A5_0F0F, 1'b0, "ws0 byte store");
    for (int i = 0; i < 3; i++) begin
      txn(1, 32'h1000_0008, 32'h0, 1'b0, 1'b0, 32'h77A5_0F0F, 1'b0, "ws0 back-to-back load");
    end
    txn(1, 32'h1000_0009, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, "ws0 misaligned load");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
